// File: rtl/uart_cmd_pkg.sv
// Shared types and timing constants for the UART command assembler.
package uart_cmd_pkg;

  typedef enum logic [1:0] {ST_WAIT, ST_ACK, ST_FULL} cmd_state_t;

  localparam int BAUD_CLKS  = 2604;
  localparam int FRAME_CLKS = 10 * BAUD_CLKS;

endpackage

// File: rtl/uart_cmd_assembler.sv
// UART command assembler: packs BYTES received bytes (first byte in the MSBs)
// into one command word, hands it over with cmd_rdy/clr_cmd_rdy and holds
// UART_rx off (rdy left unacknowledged) while a finished command is pending.
// Optional feature macro: UART_CMD_TIMEOUT_EN -- discards a partial command
// after TIMEOUT_CLKS idle cycles between bytes and pulses err_timeout.
module uart_cmd_assembler
  import uart_cmd_pkg::*;
#(
  parameter int BYTES        = 3,
  parameter int TIMEOUT_CLKS = 52080
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rdy,
  output logic               clr_rdy,
  input  logic               clr_cmd_rdy,
  output logic [8*BYTES-1:0] cmd,
  output logic               cmd_rdy,
  output logic               busy,
  output logic               err_timeout
);

  localparam int            CW       = $clog2(BYTES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BYTES);

  cmd_state_t         r_state;
  logic [CW-1:0]      r_cnt;
  logic [8*BYTES-1:0] r_shreg;
  logic [8*BYTES-1:0] r_cmd;
  logic               r_cmd_rdy;
  logic               r_busy;
  logic               r_clr_rdy;
  logic               r_err;

  logic [8*BYTES-1:0] w_shift;
  logic               w_gap_hit;

  assign w_shift = {r_shreg[8*BYTES-9:0], rx_data};

`ifdef UART_CMD_TIMEOUT_EN
  localparam int               GAP_W    = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CLKS - 1);

  logic [GAP_W-1:0] r_gap;

  assign w_gap_hit = (r_state == ST_WAIT) && (r_cnt != '0) && (r_gap == GAP_LAST);

  // Inter-byte gap timer: runs only while a partial command waits for its next byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gap <= '0;
    end else if (r_state != ST_WAIT || r_cnt == '0 || rdy || w_gap_hit) begin
      r_gap <= '0;
    end else begin
      r_gap <= r_gap + 1'b1;
    end
  end
`else
  // No gap timer in this build: a partial command waits indefinitely.
  assign w_gap_hit = (TIMEOUT_CLKS < 0);
`endif

  // Handshake FSM with byte capture, command hand-off and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_WAIT;
      r_cnt     <= '0;
      r_shreg   <= '0;
      r_cmd     <= '0;
      r_cmd_rdy <= 1'b0;
      r_busy    <= 1'b0;
      r_clr_rdy <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_gap_hit;
      case (r_state)
        ST_WAIT: begin
          if (w_gap_hit) begin
            // Timeout beats a byte arriving in the same cycle; that byte
            // is taken next cycle as the first of a fresh command.
            r_cnt  <= '0;
            r_busy <= 1'b0;
          end else if (rdy) begin
            r_shreg   <= w_shift;
            r_cnt     <= r_cnt + 1'b1;
            r_busy    <= 1'b1;
            r_clr_rdy <= 1'b1;
            r_state   <= ST_ACK;
          end
        end
        ST_ACK: begin
          // Hold the acknowledge until UART_rx drops rdy, so each byte is
          // captured exactly once.
          if (!rdy) begin
            r_clr_rdy <= 1'b0;
            if (r_cnt == CNT_LAST) begin
              r_cmd     <= r_shreg;
              r_cmd_rdy <= 1'b1;
              r_cnt     <= '0;
              r_busy    <= 1'b0;
              r_state   <= ST_FULL;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_FULL: begin
          // No acknowledge here: UART_rx keeps its byte until cmd is consumed.
          if (clr_cmd_rdy) begin
            r_cmd_rdy <= 1'b0;
            r_state   <= ST_WAIT;
          end
        end
        default: begin
          r_state   <= ST_WAIT;
          r_clr_rdy <= 1'b0;
        end
      endcase
    end
  end

  assign clr_rdy     = r_clr_rdy;
  assign cmd         = r_cmd;
  assign cmd_rdy     = r_cmd_rdy;
  assign busy        = r_busy;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed bench for uart_cmd_assembler (BYTES=3). UART_rx is modelled
// behaviourally: rdy rises with a byte and drops the cycle after clr_rdy is seen.
// Scenario 5/6 follows UART_CMD_TIMEOUT_EN.
module tb_uart_cmd_assembler;
  import uart_cmd_pkg::*;

  localparam int BYTES = 3;
  localparam int TO    = 200;
  localparam int IDLE  = 300;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rdy;
  logic        clr_rdy;
  logic        clr_cmd_rdy;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        busy;
  logic        err_timeout;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  int   clr_pulses = 0;
  int   cmd_rises  = 0;
  int   err_cycles = 0;
  logic clr_q = 1'b0;
  logic cmd_q = 1'b0;

  always #5 clk = ~clk;

  uart_cmd_assembler #(.BYTES(BYTES), .TIMEOUT_CLKS(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rdy        (rdy),
    .clr_rdy    (clr_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  // Edge/pulse monitors, sampled away from the active edge
  always @(negedge clk) begin
    clr_q <= clr_rdy;
    cmd_q <= cmd_rdy;
    if (clr_rdy && !clr_q) clr_pulses <= clr_pulses + 1;
    if (cmd_rdy && !cmd_q) cmd_rises  <= cmd_rises + 1;
    if (err_timeout)       err_cycles <= err_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One byte through the UART_rx handshake; ack wait is bounded
  task automatic send_byte(input logic [7:0] b);
    int t;
    @(negedge clk);
    rx_data = b;
    rdy     = 1'b1;
    t = 0;
    while (clr_rdy !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("ack_seen", {31'd0, clr_rdy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    rx_data     = 8'h00;
    rdy         = 1'b0;
    clr_cmd_rdy = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cmd",     {8'd0, cmd}, 32'h0);
    check("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    check("rst_busy",    {31'd0, busy}, 32'd0);
    check("rst_clr_rdy", {31'd0, clr_rdy}, 32'd0);
    check("rst_err",     {31'd0, err_timeout}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: three bytes back-to-back
    send_byte(8'h3A);
    check("t1_busy_partial", {31'd0, busy}, 32'd1);
    check("t1_rdy_partial",  {31'd0, cmd_rdy}, 32'd0);
    send_byte(8'hC5);
    send_byte(8'h01);
    #1;
    check("t1_cmd",      {8'd0, cmd}, 32'h3AC501);
    check("t1_cmd_rdy",  {31'd0, cmd_rdy}, 32'd1);
    check("t1_busy",     {31'd0, busy}, 32'd0);
    check("t1_acks",     clr_pulses, 32'd3);
    check("t1_rises",    cmd_rises, 32'd1);

    // 2: backpressure while cmd unconsumed
    @(negedge clk);
    rx_data = 8'hFF;
    rdy     = 1'b1;
    repeat (5) @(negedge clk);
    check("t2_no_ack",   {31'd0, clr_rdy}, 32'd0);
    check("t2_acks",     clr_pulses, 32'd3);
    check("t2_cmd_hold", {8'd0, cmd}, 32'h3AC501);
    check("t2_cmd_rdy",  {31'd0, cmd_rdy}, 32'd1);
    pulse_clear();
    check("t2_cleared",  {31'd0, cmd_rdy}, 32'd0);
    send_byte(8'hFF);
    check("t2_busy",     {31'd0, busy}, 32'd1);
    check("t2_cmd_keep", {8'd0, cmd}, 32'h3AC501);
    send_byte(8'h22);
    send_byte(8'h33);
    check("t2_cmd",      {8'd0, cmd}, 32'hFF2233);
    check("t2_cmd_rdy2", {31'd0, cmd_rdy}, 32'd1);

    // 3: clear and new byte in the same cycle
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    rx_data     = 8'h44;
    rdy         = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    check("t3_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    check("t3_no_ack",  {31'd0, clr_rdy}, 32'd0);
    check("t3_idle",    {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("t3_ack",     {31'd0, clr_rdy}, 32'd1);
    check("t3_busy",    {31'd0, busy}, 32'd1);
    send_byte(8'h44);
    send_byte(8'h55);
    send_byte(8'h66);
    check("t3_cmd",     {8'd0, cmd}, 32'h445566);
    pulse_clear();

    // 4: reset in the middle of a command
    send_byte(8'h12);
    send_byte(8'h34);
    check("t4_busy_pre", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t4_rst_busy", {31'd0, busy}, 32'd0);
    check("t4_rst_cmd",  {8'd0, cmd}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    check("t4_cmd",      {8'd0, cmd}, 32'hAABBCC);
    check("t4_cmd_rdy",  {31'd0, cmd_rdy}, 32'd1);
    pulse_clear();

`ifdef UART_CMD_TIMEOUT_EN
    // 5: inter-byte gap discards the partial command
    send_byte(8'h12);
    repeat (IDLE) @(negedge clk);
    check("t5_busy_drop", {31'd0, busy}, 32'd0);
    check("t5_err_once",  err_cycles, 32'd1);
    send_byte(8'h56);
    send_byte(8'h78);
    send_byte(8'h9A);
    check("t5_cmd",       {8'd0, cmd}, 32'h56789A);
    check("t5_busy",      {31'd0, busy}, 32'd0);
`else
    // 6: without the timer the partial command survives the gap
    send_byte(8'h12);
    repeat (IDLE) @(negedge clk);
    check("t6_busy_gap", {31'd0, busy}, 32'd1);
    send_byte(8'h56);
    send_byte(8'h78);
    check("t6_cmd",      {8'd0, cmd}, 32'h125678);
    @(negedge clk);
    rx_data = 8'h9A;
    rdy     = 1'b1;
    repeat (4) @(negedge clk);
    check("t6_no_ack",   {31'd0, clr_rdy}, 32'd0);
    pulse_clear();
    send_byte(8'h9A);
    check("t6_busy",     {31'd0, busy}, 32'd1);
    check("t6_cmd_keep", {8'd0, cmd}, 32'h125678);
    check("t6_no_err",   err_cycles, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
